// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command sequencer slice.
// Combinational definitions only; no latency.
// No flow control of its own.
package i2c_pkg;

    // Command codes understood by mod_I2C; CMD_IDLE doubles as "no request"
    localparam logic [3:0] CMD_IDLE  = 4'd0;
    localparam logic [3:0] CMD_WRITE = 4'd1;
    localparam logic [3:0] CMD_READ  = 4'd2;

    // Queued request layout: {cmd[19:16], addr[15:8], data[7:0]}
    localparam int ENTRY_W   = 20;
    localparam int CMD_LSB   = 16;
    localparam int ADDR_LSB  = 8;
    localparam int DATA_LSB  = 0;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
    } req_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } seq_state_e;

    // Timeout counter width covers the full 1..65535 range
    localparam int CNT_W = 16;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Bundle of request, mod_I2C drive and status signals around the sequencer.
// Pure wiring; no latency.
// Request side uses valid/ready; mod_I2C side uses its ready level as handshake.
interface i2c_cmd_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cmd;
    logic [7:0]       req_addr;
    logic [7:0]       req_data;
    logic [3:0]       command;
    logic [7:0]       address;
    logic [7:0]       data;
    logic             i2c_ready;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic             err_clr;
    logic [LVL_W-1:0] fifo_level;

    // Sequencer side
    modport slave (
        input  req_valid, req_cmd, req_addr, req_data, i2c_ready, err_clr,
        output req_ready, command, address, data, busy, done, timeout_err, fifo_level
    );

    // Control logic / master model side
    modport master (
        output req_valid, req_cmd, req_addr, req_data, i2c_ready, err_clr,
        input  req_ready, command, address, data, busy, done, timeout_err, fifo_level
    );

endinterface

// File: rtl/i2c_req_fifo.sv
// Generic synchronous FIFO holding queued I2C requests.
// Write visible at the head one cycle after push; head is read combinationally.
// Pushes are ignored while full_o is set; full_o is a registered flag.
module i2c_req_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             push_ok, pop_ok;

    assign push_ok    = push_i & ~full_q;
    assign pop_ok     = pop_i & (level_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;

    // Pointer and occupancy next-state; pointers wrap naturally at power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_FULL);
    end

    // Pointer, level and full-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C requests and drives them one at a time into mod_I2C.
// Request accepted at edge N issues after edge N+1 when the master is idle.
// req_ready drops when the queue is full; a command not accepted in time is dropped with timeout_err.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int ACCEPT_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    i2c_cmd_sequencer_if.slave     bus
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(ACCEPT_TIMEOUT);

    seq_state_e        state_q, state_d;
    req_entry_t        cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              set_err;
    logic              pop;

    logic              fifo_push;
    logic [ENTRY_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    req_entry_t        head_entry;

    // Zero-command requests complete their handshake but are never stored
    assign fifo_push  = bus.req_valid & ~fifo_full & (bus.req_cmd != CMD_IDLE);
    assign head_entry = req_entry_t'(fifo_head);

    i2c_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i ({bus.req_cmd, bus.req_addr, bus.req_data}),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    // Sequencer next-state: pop/issue, wait for accept (or time out), wait for completion
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        set_err = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && bus.i2c_ready) begin
                    pop     = 1'b1;
                    cur_d   = head_entry;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.i2c_ready) begin
                    cur_d.cmd = CMD_IDLE;
                    state_d   = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TIMEOUT_LIM) begin
                        cur_d.cmd = CMD_IDLE;
                        set_err   = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                // address/data stay on the bus until the master finishes
                if (bus.i2c_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cur_d.cmd = CMD_IDLE;
                state_d   = ST_IDLE;
            end
        endcase

        // A new timeout wins over a simultaneous clear so no error is lost
        if (set_err) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Sequencer state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready   = ~fifo_full;
    assign bus.command     = cur_q.cmd;
    assign bus.address     = cur_q.addr;
    assign bus.data        = cur_q.data;
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;
    assign bus.fifo_level  = fifo_level;
    assign bus.busy        = (state_q != ST_IDLE) | (fifo_level != '0);

endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Upstream command feeder for the `mod_I2C` master. Buffers I2C transaction requests (command, device/register address, data byte) from control logic in a small FIFO. Issues them one at a time on `mod_I2C`'s `command`/`address`/`data` inputs, using `mod_I2C`'s `ready` as the accept/complete handshake. Reports completion, and times out if the master never accepts a command.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: request FIFO entries; power of two, ≥2.
- `ACCEPT_TIMEOUT`, default 255: maximum cycles `command` is held waiting for `i2c_ready` to fall; range 1..65535.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; transfer on `req_valid & req_ready`.
- `req_cmd`  in  4  command code; 0 = no-op.
- `req_addr`  in  8  address byte.
- `req_data`  in  8  data byte.
- `command`  out  4  to `mod_I2C.command`.
- `address`  out  8  to `mod_I2C.address`.
- `data`  out  8  to `mod_I2C.data`.
- `i2c_ready`  in  1  from `mod_I2C.ready`; 1 = idle/accepting.
- `busy`  out  1  FIFO non-empty or transaction in flight.
- `done`  out  1  one-cycle pulse per completed transaction.
- `timeout_err`  out  1  sticky; set on accept timeout.
- `err_clr`  in  1  clears `timeout_err`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current entry count.

## Operation
- Request FIFO:
  - Entries are 20 bits: {cmd, addr, data}.
  - `req_ready` = registered not-full.
  - A handshake with `req_cmd`==0 completes but stores nothing.
- State machine:
  - IDLE:
    - Taken when the FIFO is non-empty and `i2c_ready`=1.
    - Pop head; load `command`/`address`/`data`; clear timeout counter; go to ISSUE.
  - ISSUE:
    - Hold all outputs.
    - On `i2c_ready`=0: `command`←0, go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches `ACCEPT_TIMEOUT`: `command`←0, `timeout_err`←1, entry dropped, go to IDLE.
  - WAIT_DONE:
    - `address`/`data` stay held.
    - On `i2c_ready`=1: `done`←1 for one cycle, go to IDLE.
- FIFO behaviour:
  - Push and pop in the same cycle are legal; `fifo_level` is unchanged.
  - No push while full (`req_ready`=0).
  - Order is strictly FIFO; entries are never reordered.
- `timeout_err`: set has priority over `err_clr` in the same cycle.
- `busy` = (state≠IDLE) | (fifo_level≠0).

## Timing
- Reset values:
  - `command`=0, `address`=0, `data`=0.
  - `done`=0, `timeout_err`=0, `fifo_level`=0.
  - `busy`=0, `req_ready`=1.
  - State IDLE; FIFO pointers 0.
- Reset mid-transaction:
  - `command` is 0 after the reset edge.
  - Queued entries are discarded.
  - No `done` pulse.
- Issue latency:
  - Request accepted at edge N with the master idle → `command` valid after edge N+1.
  - After a completion (`done` at edge M), the next queued entry issues at edge M+1 if `i2c_ready`=1.
- `command` assertion:
  - Nonzero for at least 1 cycle.
  - Deasserts the edge after `i2c_ready` is first sampled low.
- `address`/`data` are stable from the pop edge until the edge after WAIT_DONE exits.
- Timeout: `command` is nonzero for exactly `ACCEPT_TIMEOUT` cycles, then 0 with `timeout_err` rising on the same edge.
- Wrap-around: FIFO pointers wrap modulo `FIFO_DEPTH`. `fifo_level` uses an extra bit to distinguish full from empty.

## Structure
- Shared package `i2c_pkg`:
  - Command codes `CMD_IDLE`=4'd0, `CMD_WRITE`=4'd1, `CMD_READ`=4'd2.
  - Sequencer state encoding (IDLE/ISSUE/WAIT_DONE).
  - 20-bit entry layout constants.
- Sub-module `i2c_req_fifo`:
  - Generic synchronous FIFO, width 20, depth `FIFO_DEPTH`.
  - Outputs full/empty/level.
  - The sequencer FSM and timeout counter live in the top module.

## Test plan
- Single write:
  - Stimulus: push {1, 0x3C, 0xA5}; master model drops `i2c_ready` 3 cycles after seeing `command`, raises it 20 cycles later.
  - Response: `command`=1 for 3 cycles, then 0; `address`=0x3C and `data`=0xA5 held throughout; one `done` pulse; `fifo_level`=0; `busy` falls.
- Full FIFO:
  - Stimulus: `i2c_ready` held 0; push 5 requests (addr 0x10..0x14).
  - Response: after 4 pushes, `req_ready`=0 and `fifo_level`=4; after releasing `i2c_ready`, addresses 0x10..0x13 issue in order, then 0x14 once space frees.
- Timeout:
  - Stimulus: `ACCEPT_TIMEOUT`=8; `i2c_ready` stuck at 1.
  - Response: `command` nonzero for 8 cycles, then 0; `timeout_err`=1; no `done`; next entry issues the following cycle.
- Error priority:
  - Stimulus: `err_clr`=1 on the timeout cycle.
  - Response: `timeout_err` stays 1; the next `err_clr` clears it.
- Reset mid-WAIT_DONE:
  - Stimulus: 2 entries queued, `rst` pulsed while the first is in WAIT_DONE.
  - Response: `command`=0, `fifo_level`=0, `busy`=0, no `done`.
- Zero command:
  - Stimulus: push `req_cmd`=0.
  - Response: handshake completes; `fifo_level` stays 0; `command` never asserted.
